// File: rtl/gonso_wb_pkg.sv
// gonso_wb_pkg: shared definitions for the gonso_wb_regbank register bank.
// Holds the register offsets, the ID constant, the STATUS/CCTRL bit positions,
// the channel region layout and the per-channel FSM state encoding.
package gonso_wb_pkg;

    // Global register offsets (byte offsets from the bank base)
    localparam logic [7:0] OFF_ID       = 8'h00;
    localparam logic [7:0] OFF_CTRL     = 8'h04;
    localparam logic [7:0] OFF_STATUS   = 8'h08;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h0C;

    // Channel region: channel k lives at CHAN_BASE + k*CHAN_STRIDE
    localparam logic [7:0] CHAN_BASE   = 8'h20;
    localparam logic [7:0] CHAN_STRIDE = 8'h10;

    // Offsets inside one channel window
    localparam logic [3:0] COFF_DIN   = 4'h0;
    localparam logic [3:0] COFF_DOUT  = 4'h4;
    localparam logic [3:0] COFF_CCTRL = 4'h8;

    localparam logic [31:0] ID_VALUE = 32'h474F_0200;

    // Bit positions
    localparam int CTRL_EN_BIT      = 0;
    localparam int STATUS_BUSY_LSB  = 16;
    localparam int STATUS_OVR_BIT   = 31;
    localparam int CCTRL_START_BIT  = 0;
    localparam int CCTRL_CONT_BIT   = 1;

    // CH_GAP is the single request-low cycle between back-to-back
    // continuous operations; it always proceeds to CH_BUSY.
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_BUSY = 2'd1,
        CH_GAP  = 2'd2
    } chan_state_e;

    // Expand the four Wishbone byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gonso_wb_chan.sv
// gonso_wb_chan: one compute-engine channel of gonso_wb_regbank.
// Holds the DIN / DOUT / continuous registers, the done flag and the
// IDLE -> BUSY -> IDLE handshake FSM towards the external engine.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   enable_i               global enable from CTRL
//   din_we_i/din_mask_i/din_wdata_i   byte-masked DIN write
//   cctrl_we_i/start_i/cont_i         CCTRL write (byte 0 strobed)
//   done_clr_i             W1C clear of the done flag
//   eng_ack_i/eng_dout_i   engine completion pulse and result
//   eng_req_o/eng_din_o    request and snapshotted operand to the engine
//   din_o, cont_o          current register values
//   dout_nxt_o, busy_nxt_o, done_nxt_o  post-edge values, so a read sampled
//                          on the completion edge already sees the result
//   done_o                 registered done flag (interrupt source)
//   overrun_o              pulse: start written while busy
module gonso_wb_chan
    import gonso_wb_pkg::*;
#(
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              din_we_i,
    input  logic [DATA_W-1:0] din_mask_i,
    input  logic [DATA_W-1:0] din_wdata_i,
    input  logic              cctrl_we_i,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic              done_clr_i,
    input  logic              eng_ack_i,
    input  logic [DATA_W-1:0] eng_dout_i,
    output logic              eng_req_o,
    output logic [DATA_W-1:0] eng_din_o,
    output logic [DATA_W-1:0] din_o,
    output logic [DATA_W-1:0] dout_nxt_o,
    output logic              cont_o,
    output logic              busy_nxt_o,
    output logic              done_o,
    output logic              done_nxt_o,
    output logic              overrun_o
);

    chan_state_e       state_q, state_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] eng_din_q, eng_din_d;
    logic              cont_q, cont_d;
    logic              done_q, done_d;

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        dout_d    = dout_q;
        eng_din_d = eng_din_q;
        cont_d    = cont_q;
        // clear first so a completion in the same cycle wins
        done_d    = done_q & ~done_clr_i;
        overrun_o = 1'b0;

        if (din_we_i) begin
            din_d = (din_q & ~din_mask_i) | (din_wdata_i & din_mask_i);
        end
        if (cctrl_we_i) begin
            cont_d = cont_i;
        end

        case (state_q)
            CH_IDLE: begin
                if (cctrl_we_i && start_i && enable_i) begin
                    state_d   = CH_BUSY;
                    eng_din_d = din_q;
                end
            end
            CH_BUSY: begin
                if (cctrl_we_i && start_i) begin
                    overrun_o = 1'b1;
                end
                if (eng_ack_i) begin
                    dout_d  = eng_dout_i;
                    done_d  = 1'b1;
                    state_d = (cont_q && enable_i) ? CH_GAP : CH_IDLE;
                end
            end
            CH_GAP: begin
                // fresh snapshot for the next continuous operation
                state_d   = CH_BUSY;
                eng_din_d = din_q;
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CH_IDLE;
            din_q     <= '0;
            dout_q    <= '0;
            eng_din_q <= '0;
            cont_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            eng_din_q <= eng_din_d;
            cont_q    <= cont_d;
            done_q    <= done_d;
        end
    end

    assign eng_req_o  = (state_q == CH_BUSY);
    assign eng_din_o  = eng_din_q;
    assign din_o      = din_q;
    assign dout_nxt_o = dout_d;
    assign cont_o     = cont_q;
    assign busy_nxt_o = (state_d == CH_BUSY);
    assign done_o     = done_q;
    assign done_nxt_o = done_d;

endmodule

// File: rtl/gonso_wb_regbank.sv
// gonso_wb_regbank: Wishbone slave register bank fronting NCH compute-engine
// channels. Top level holds the bus decode, CTRL, STATUS assembly, overrun
// flag and the optional interrupt; each channel is a gonso_wb_chan instance.
// Build option: define GONSO_WB_IRQ_EN to add irq_o and the IRQ_MASK register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i     Wishbone cycle, strobe, write
//   wbs_adr_i/dat_i/sel_i    byte address, write data, byte lanes
//   wbs_dat_o, wbs_ack_o     registered read data and acknowledge
//   eng_req_o, eng_din_o     per-channel request and operand
//   eng_ack_i, eng_dout_i    per-channel completion pulse and result
//   irq_o                    interrupt (GONSO_WB_IRQ_EN only)
module gonso_wb_regbank
    import gonso_wb_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          DATA_W    = 20,
    parameter logic [31:0] BASE_ADDR = 32'h3003_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [3:0]            wbs_sel_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic [NCH-1:0]        eng_req_o,
    output logic [NCH*DATA_W-1:0] eng_din_o,
    input  logic [NCH-1:0]        eng_ack_i,
    input  logic [NCH*DATA_W-1:0] eng_dout_i
`ifdef GONSO_WB_IRQ_EN
    ,
    output logic                  irq_o
`endif
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        en_q, en_d;
    logic        ovr_q, ovr_d;

    logic        valid;
    logic        hit_base;
    logic        bus_wr;
    logic        status_wr;
    logic [7:0]  off;
    logic [31:0] lane_m;
    logic [31:0] rdata;

    logic [NCH-1:0]    chan_hit;
    logic [NCH-1:0]    done_clr;
    logic [NCH-1:0]    chan_cont;
    logic [NCH-1:0]    chan_busy_nxt;
    logic [NCH-1:0]    chan_done_q;
    logic [NCH-1:0]    chan_done_nxt;
    logic [NCH-1:0]    chan_ovr;
    logic [DATA_W-1:0] chan_din      [NCH];
    logic [DATA_W-1:0] chan_dout_nxt [NCH];

    // a held strobe is served again only after ack drops
    assign valid     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign hit_base  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off       = wbs_adr_i[7:0];
    assign bus_wr    = valid & wbs_we_i & hit_base;
    assign status_wr = bus_wr & (off == OFF_STATUS);
    assign lane_m    = lane_mask(wbs_sel_i);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            localparam logic [7:0] CH_OFF = CHAN_BASE + 8'(gi) * CHAN_STRIDE;

            assign chan_hit[gi] = (off[7:4] == CH_OFF[7:4]);
            assign done_clr[gi] = status_wr & wbs_sel_i[0] & wbs_dat_i[gi];

            gonso_wb_chan #(
                .DATA_W (DATA_W)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .enable_i    (en_q),
                .din_we_i    (bus_wr & chan_hit[gi] & (off[3:0] == COFF_DIN)),
                .din_mask_i  (lane_m[DATA_W-1:0]),
                .din_wdata_i (wbs_dat_i[DATA_W-1:0]),
                .cctrl_we_i  (bus_wr & chan_hit[gi] & (off[3:0] == COFF_CCTRL) & wbs_sel_i[0]),
                .start_i     (wbs_dat_i[CCTRL_START_BIT]),
                .cont_i      (wbs_dat_i[CCTRL_CONT_BIT]),
                .done_clr_i  (done_clr[gi]),
                .eng_ack_i   (eng_ack_i[gi]),
                .eng_dout_i  (eng_dout_i[gi*DATA_W +: DATA_W]),
                .eng_req_o   (eng_req_o[gi]),
                .eng_din_o   (eng_din_o[gi*DATA_W +: DATA_W]),
                .din_o       (chan_din[gi]),
                .dout_nxt_o  (chan_dout_nxt[gi]),
                .cont_o      (chan_cont[gi]),
                .busy_nxt_o  (chan_busy_nxt[gi]),
                .done_o      (chan_done_q[gi]),
                .done_nxt_o  (chan_done_nxt[gi]),
                .overrun_o   (chan_ovr[gi])
            );
        end
    endgenerate

`ifdef GONSO_WB_IRQ_EN
    logic [NCH-1:0] mask_q, mask_d;
    logic           irq_q, irq_d;
`endif

    // Read mux. Channel DOUT/busy/done use post-edge values so that an
    // engine completion on the sampling edge is already visible.
    always_comb begin
        rdata = '0;
        if (hit_base) begin
            if (off == OFF_ID) begin
                rdata = ID_VALUE;
            end else if (off == OFF_CTRL) begin
                rdata[CTRL_EN_BIT] = en_q;
            end else if (off == OFF_STATUS) begin
                rdata[NCH-1:0]                = chan_done_nxt;
                rdata[STATUS_BUSY_LSB +: NCH] = chan_busy_nxt;
                rdata[STATUS_OVR_BIT]         = ovr_q;
            end else if (off == OFF_IRQ_MASK) begin
`ifdef GONSO_WB_IRQ_EN
                rdata[NCH-1:0] = mask_q;
`endif
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (chan_hit[k]) begin
                        case (off[3:0])
                            COFF_DIN:   rdata[DATA_W-1:0]     = chan_din[k];
                            COFF_DOUT:  rdata[DATA_W-1:0]     = chan_dout_nxt[k];
                            COFF_CCTRL: rdata[CCTRL_CONT_BIT] = chan_cont[k];
                            default:    rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        ack_d = valid;
        dat_d = (valid && !wbs_we_i) ? rdata : '0;

        en_d = en_q;
        if (bus_wr && (off == OFF_CTRL) && wbs_sel_i[0]) begin
            en_d = wbs_dat_i[CTRL_EN_BIT];
        end

        // overrun set takes priority over its W1C
        ovr_d = ovr_q;
        if (status_wr && wbs_sel_i[3] && wbs_dat_i[STATUS_OVR_BIT]) begin
            ovr_d = 1'b0;
        end
        if (|chan_ovr) begin
            ovr_d = 1'b1;
        end
    end

`ifdef GONSO_WB_IRQ_EN
    always_comb begin
        mask_d = mask_q;
        if (bus_wr && (off == OFF_IRQ_MASK) && wbs_sel_i[0]) begin
            mask_d = wbs_dat_i[NCH-1:0];
        end
        irq_d = |(chan_done_q & mask_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            en_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            en_q  <= en_d;
            ovr_q <= ovr_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: doc/gonso_wb_regbank.md
# gonso_wb_regbank

Parametrised Wishbone slave register bank that fronts NCH independent compute-engine channels in the user area. Each channel has a data-in register, a captured data-out register and a start/done handshake to an external engine; global enable, sticky status and an optional interrupt are added. It supersedes the fixed three-register, free-running front end and sits between the Caravel Wishbone bus and the engine instances.

## Interface
- NCH, 2, number of channels (1..8)
- DATA_W, 20, channel data width in bits (1..32)
- BASE_ADDR, 32'h3003_0000, base address; only bits [31:8] are decoded

- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1  Wishbone cycle, strobe and write (1 = write)
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_sel_i  input  4  byte-lane strobes
- wbs_dat_o  output  32  read data, registered
- wbs_ack_o  output  1  acknowledge, registered
- eng_req_o  output  NCH  per-channel request, held until acknowledged
- eng_din_o  output  NCH*DATA_W  per-channel operand, channel k at [k*DATA_W +: DATA_W]
- eng_ack_i  input  NCH  per-channel completion pulse
- eng_dout_i  input  NCH*DATA_W  per-channel result, valid while eng_ack_i[k] is high
- irq_o  output  1  interrupt; present only with GONSO_WB_IRQ_EN

## Operation
- Address map, offsets from BASE_ADDR:
  - 0x00 ID, RO: 32'h474F_0200
  - 0x04 CTRL: bit0 is enable
  - 0x08 STATUS: [NCH-1:0] done, W1C; [16+NCH-1:16] busy, RO; bit31 overrun, W1C
  - 0x0C IRQ_MASK: [NCH-1:0]
  - 0x20+k*0x10 channel k:
    - +0 DIN, RW
    - +4 DOUT, RO
    - +8 CCTRL: bit1 continuous, RW; bit0 start, write-only, reads 0
- Writes honour wbs_sel_i byte lanes. Bits above DATA_W read 0 and ignore writes.
- A write to a RO register is ignored. An unmapped offset or a non-matching [31:8] is still acknowledged, reads 0 and has no side effect.
- Per-channel FSM, IDLE -> BUSY -> IDLE:
  - IDLE -> BUSY: start=1 is written while CTRL.enable=1. DIN is snapshotted into eng_din_o[k], eng_req_o[k] goes to 1 and busy is set.
  - BUSY on eng_ack_i[k]: eng_dout_i is captured into DOUT, eng_req_o goes to 0 and done is set. If continuous=1 and enable=1, the channel re-enters BUSY on the next cycle with a fresh DIN snapshot; otherwise it returns to IDLE.
- Boundary rules:
  - start while BUSY: ignored; sets overrun.
  - start while enable=0: ignored; no flag.
  - Clearing enable while BUSY does not abort. The channel completes and then stops.
  - DIN writes while BUSY do not change eng_din_o.
  - eng_ack_i while IDLE is ignored.
  - A done W1C in the same cycle as eng_ack_i: set wins.

## Timing
- Reset values: wbs_dat_o=0, wbs_ack_o=0, eng_req_o=0, eng_din_o=0, irq_o=0. All registers are 0 and all FSMs are IDLE.
- Bus handshake:
  - A request is valid when cyc & stb & !ack.
  - wbs_ack_o rises on the edge that samples a valid request and holds for exactly one cycle, with wbs_dat_o valid in that same cycle.
  - Minimum access is 2 cycles. A held stb is served again after ack drops.
- Register writes take effect on the ack edge. A start write asserts eng_req_o on that same edge.
- eng_ack_i sampled at edge n updates DOUT, done and busy at edge n, so they are visible to a read issued at n.
- In continuous mode there is exactly one req-low cycle between operations.
- A reset asserted mid-operation drops eng_req_o immediately; engines must tolerate an abandoned request.

## Configuration
- GONSO_WB_IRQ_EN defined:
  - irq_o = |(done & IRQ_MASK), registered, with one cycle latency from done or mask change.
- GONSO_WB_IRQ_EN undefined:
  - irq_o does not exist.
  - IRQ_MASK reads 0 and ignores writes.

## Structure
- Package gonso_wb_pkg holds:
  - register offsets
  - the ID constant
  - STATUS and CCTRL bit positions
  - the channel stride (0x10) and the channel region base (0x20)
  - the channel FSM state enum
- Sub-module gonso_wb_chan holds one channel's FSM, DIN/DOUT/CCTRL registers and flags, generated NCH times. The top level keeps the bus decode, CTRL, STATUS assembly and IRQ.

## Test plan
- Reset, then read 0x00 -> ack one cycle later with 32'h474F_0200. Read 0x04 -> 0.
- Enable, write DIN0=0x12345, start ch0, engine acks after 3 cycles with 0x54321 -> DOUT0=0x54321, STATUS=0x1, eng_req_o[0] high for 3 cycles.
- Start ch0 while busy -> STATUS bit31=1, eng_din_o unchanged. Writing 0x8000_0001 to STATUS clears overrun and done.
- Continuous ch1 with DATA_W=20, DIN changed mid-run -> the next request carries the new DIN after one req-low cycle. Clearing enable stops after the current ack.
- Write with wbs_sel_i=4'b0001 to DIN0 over 0xFFFFF -> DIN0=0xFFF00|byte0 and upper bits unchanged. Read 0xF0 -> ack with 0.
- With GONSO_WB_IRQ_EN: mask=0x2, ch1 completes -> irq_o=1 on the next cycle. W1C done1 -> irq_o=0.
